// File: rtl/control_sequencer.sv
// control_sequencer: Moore step sequencer for the single-bus datapath.
// One register-transfer step per clock. The sequencer fetches (T0-T2), decodes IR[31:27],
// then runs the execute steps of that instruction class. Register strobes are select-and-encode:
// Gra/Grb/Grc pick the IR field, and Rin/Rout/BAout act on the selected register.
module control_sequencer #(
  parameter logic [4:0] ADD_OP         = 5'b00011,
  parameter bit         RESUME_ON_STOP = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        stop,
  output logic        run,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        PCout,
  output logic        PCin,
  output logic        incPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZHighOut,
  output logic        ZLowOut,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic [4:0]  alu_op,
  output logic [3:0]  step
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALTED = 4'd15
  } state_e;

  state_e state_q, state_d;
  logic   halt_instr_q, halt_instr_d;

  logic [4:0] op;
  logic is_rtype, is_imm, is_muldiv, is_unary;
  logic is_ld, is_ldi, is_st, is_mfhi, is_mflo, is_halt, is_mem;
  logic [4:0] imm_alu;
  state_e last_step;
  state_e boundary_next;

  // The register fields of IR are consumed by the datapath's select-and-encode logic;
  // only the opcode steers sequencing here.
  logic ir_fields_unused;
  assign ir_fields_unused = ^IR[26:0];

  assign op = IR[31:27];

  // Instruction class decode and the final execute step of each class
  always_comb begin
    is_rtype  = (op >= 5'b00011) && (op <= 5'b01011);
    is_imm    = (op >= 5'b01100) && (op <= 5'b01110);
    is_muldiv = (op == 5'b01111) || (op == 5'b10000);
    is_unary  = (op == 5'b10001) || (op == 5'b10010);
    is_ld     = (op == 5'b00000);
    is_ldi    = (op == 5'b00001);
    is_st     = (op == 5'b00010);
    is_mfhi   = (op == 5'b11000);
    is_mflo   = (op == 5'b11001);
    is_halt   = (op == 5'b11011);
    is_mem    = is_ld || is_ldi || is_st;

    case (op)
      5'b01100: imm_alu = ADD_OP;
      5'b01101: imm_alu = 5'b00101;
      default:  imm_alu = 5'b00110;
    endcase

    if (is_rtype || is_imm || is_ldi)  last_step = S_T5;
    else if (is_muldiv)                last_step = S_T6;
    else if (is_unary)                 last_step = S_T4;
    else if (is_ld || is_st)           last_step = S_T7;
    else if (is_mfhi || is_mflo)       last_step = S_T3;
    else                               last_step = S_T2;
  end

  // Next-step selection; stop is only looked at on the last step of an instruction
  always_comb begin
    state_d       = state_q;
    halt_instr_d  = halt_instr_q;
    boundary_next = stop ? S_HALTED : S_T0;
    case (state_q)
      S_RST:    state_d = S_T0;
      S_T0:     state_d = S_T1;
      S_T1:     state_d = S_T2;
      S_T2: begin
        if (is_halt) begin
          state_d      = S_HALTED;
          halt_instr_d = 1'b1;
        end else if (last_step == S_T2) begin
          state_d = boundary_next;
        end else begin
          state_d = S_T3;
        end
      end
      S_HALTED: begin
        if (RESUME_ON_STOP && !halt_instr_q && !stop) state_d = S_T0;
      end
      default: begin
        // Treat any step at or past the class's final step as the boundary so a
        // misbehaving IR can never walk the sequencer into an unused encoding.
        if ((state_q >= last_step) || (state_q == S_T7)) state_d = boundary_next;
        else state_d = state_e'(state_q + 4'd1);
      end
    endcase
  end

  // Step register and halt-instruction flag, with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_RST;
      halt_instr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      halt_instr_q <= halt_instr_d;
    end
  end

  // Strobe decode from the current step and opcode; clr forces every output low at once
  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, incPC, MARin, MDRin, MDRout,
     Read, Write, IRin, Yin, Zin, ZHighOut, ZLowOut, HIin, HIout, LOin, LOout, run} = '0;
    alu_op = 5'b0;
    step   = state_q;
    run    = (state_q != S_RST) && (state_q != S_HALTED);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1; end
      S_T1: begin ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_rtype || is_imm)  begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_muldiv)      begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_unary)       begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
        else if (is_mem)         begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        else if (is_mfhi)        begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_mflo)        begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      S_T4: begin
        if (is_rtype)            begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
        else if (is_imm)         begin Cout = 1'b1; Zin = 1'b1; alu_op = imm_alu; end
        else if (is_muldiv)      begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
        else if (is_unary)       begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_mem)         begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; end
      end
      S_T5: begin
        if (is_rtype || is_imm || is_ldi) begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_muldiv)      begin ZLowOut = 1'b1; LOin = 1'b1; end
        else if (is_ld || is_st) begin ZLowOut = 1'b1; MARin = 1'b1; end
      end
      S_T6: begin
        if (is_muldiv)           begin ZHighOut = 1'b1; HIin = 1'b1; end
        else if (is_ld)          begin Read = 1'b1; MDRin = 1'b1; end
        else if (is_st)          begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      end
      S_T7: begin
        if (is_ld)               begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_st)          Write = 1'b1;
      end
      default: ;
    endcase
    if (clr) begin
      {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, incPC, MARin, MDRin, MDRout,
       Read, Write, IRin, Yin, Zin, ZHighOut, ZLowOut, HIin, HIout, LOin, LOout, run} = '0;
      alu_op = 5'b0;
      step   = 4'd0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a microprogram-queue model predicts every cycle's strobes,
// and directed sequences pin the model with hand-written literal expectations.
module tb_control_sequencer;

  localparam logic [4:0] ADD_OP         = 5'b00011;
  localparam bit         RESUME_ON_STOP = 1'b1;

  // Strobe bit positions in the packed comparison vector
  localparam logic [24:0] GRA = 25'd1 << 0,  GRB = 25'd1 << 1,  GRC = 25'd1 << 2,  RIN = 25'd1 << 3;
  localparam logic [24:0] ROUT = 25'd1 << 4, BAOUT = 25'd1 << 5, COUT = 25'd1 << 6, PCOUT = 25'd1 << 7;
  localparam logic [24:0] PCIN = 25'd1 << 8, INCPC = 25'd1 << 9, MARIN = 25'd1 << 10, MDRIN = 25'd1 << 11;
  localparam logic [24:0] MDROUT = 25'd1 << 12, READ = 25'd1 << 13, WRITE = 25'd1 << 14, IRIN = 25'd1 << 15;
  localparam logic [24:0] YIN = 25'd1 << 16, ZIN = 25'd1 << 17, ZHI = 25'd1 << 18, ZLO = 25'd1 << 19;
  localparam logic [24:0] HIIN = 25'd1 << 20, HIOUT = 25'd1 << 21, LOIN = 25'd1 << 22, LOOUT = 25'd1 << 23;
  localparam logic [24:0] RUN = 25'd1 << 24;

  localparam logic [31:0] IR_ADD  = 32'h1A918000;                       // add R5,R2,R3
  localparam logic [31:0] IR_DIV  = {5'b01111, 4'd2, 4'd3, 19'd0};      // div R2,R3
  localparam logic [31:0] IR_LD   = {5'b00000, 4'd1, 4'd0, 19'h00055};  // ld R1,0x55(R0)
  localparam logic [31:0] IR_HALT = {5'b11011, 27'd0};
  localparam logic [31:0] IR_NOP  = {5'b11010, 27'd0};

  logic clk = 1'b0;
  logic clr, stop;
  logic [31:0] IR;
  logic run, Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, incPC, MARin, MDRin, MDRout;
  logic Read, Write, IRin, Yin, Zin, ZHighOut, ZLowOut, HIin, HIout, LOin, LOout;
  logic [4:0] alu_op;
  logic [3:0] step;
  logic [24:0] dut_vec;

  int n_chk = 0;
  int n_fail = 0;

  control_sequencer #(.ADD_OP(ADD_OP), .RESUME_ON_STOP(RESUME_ON_STOP)) dut (
    .clk(clk), .clr(clr), .IR(IR), .stop(stop), .run(run),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .PCout(PCout), .PCin(PCin), .incPC(incPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .ZHighOut(ZHighOut), .ZLowOut(ZLowOut), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
    .alu_op(alu_op), .step(step)
  );

  assign dut_vec = {run, LOout, LOin, HIout, HIin, ZLowOut, ZHighOut, Zin, Yin, IRin, Write, Read,
                    MDRout, MDRin, MARin, incPC, PCin, PCout, Cout, BAout, Rout, Rin, Grc, Grb, Gra};

  always #5 clk = ~clk;

  // ---------------- behavioural model: a queue of pending micro-steps ----------------
  typedef struct packed {
    logic [3:0]  step;
    logic [24:0] vec;
    logic [4:0]  alu;
  } ent_t;

  localparam int M_RST = 0, M_RUN = 1, M_HALT = 2;
  ent_t mq[$];
  ent_t m_cur;
  int   mmode = M_RST;
  bit   mhalt = 1'b0;

  task automatic push(input logic [3:0] st, input logic [24:0] v, input logic [4:0] a);
    ent_t e;
    e.step = st; e.vec = v | RUN; e.alu = a;
    mq.push_back(e);
  endtask

  task automatic load_fetch();
    mq.delete();
    push(4'd1, PCOUT | MARIN | INCPC | ZIN, 5'd0);
    push(4'd2, ZLO | PCIN | READ | MDRIN, 5'd0);
    push(4'd3, MDROUT | IRIN, 5'd0);
  endtask

  // Execute micro-steps for an opcode; step numbers are T-index + 1
  task automatic append_exec(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11) begin
      push(4'd4, GRB | ROUT | YIN, 5'd0);
      push(4'd5, GRC | ROUT | ZIN, op);
      push(4'd6, ZLO | GRA | RIN, 5'd0);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      push(4'd4, GRB | ROUT | YIN, 5'd0);
      push(4'd5, COUT | ZIN, (op == 5'd12) ? ADD_OP : (op == 5'd13) ? 5'b00101 : 5'b00110);
      push(4'd6, ZLO | GRA | RIN, 5'd0);
    end else if (op == 5'd15 || op == 5'd16) begin
      push(4'd4, GRA | ROUT | YIN, 5'd0);
      push(4'd5, GRB | ROUT | ZIN, op);
      push(4'd6, ZLO | LOIN, 5'd0);
      push(4'd7, ZHI | HIIN, 5'd0);
    end else if (op == 5'd17 || op == 5'd18) begin
      push(4'd4, GRB | ROUT | ZIN, op);
      push(4'd5, ZLO | GRA | RIN, 5'd0);
    end else if (op <= 5'd2) begin
      push(4'd4, GRB | BAOUT | YIN, 5'd0);
      push(4'd5, COUT | ZIN, ADD_OP);
      if (op == 5'd1) begin
        push(4'd6, ZLO | GRA | RIN, 5'd0);
      end else begin
        push(4'd6, ZLO | MARIN, 5'd0);
        if (op == 5'd0) begin
          push(4'd7, READ | MDRIN, 5'd0);
          push(4'd8, MDROUT | GRA | RIN, 5'd0);
        end else begin
          push(4'd7, GRA | ROUT | MDRIN, 5'd0);
          push(4'd8, WRITE, 5'd0);
        end
      end
    end else if (op == 5'd24) begin
      push(4'd4, HIOUT | GRA | RIN, 5'd0);
    end else if (op == 5'd25) begin
      push(4'd4, LOOUT | GRA | RIN, 5'd0);
    end
  endtask

  always @(posedge clk) begin
    if (clr) begin
      mmode = M_RST; mhalt = 1'b0; mq.delete();
    end else if (mmode == M_RST) begin
      mmode = M_RUN; load_fetch();
    end else if (mmode == M_HALT) begin
      if (RESUME_ON_STOP && !mhalt && !stop) begin
        mmode = M_RUN; load_fetch();
      end
    end else begin
      m_cur = mq.pop_front();
      if (m_cur.step == 4'd3) begin
        if (IR[31:27] == 5'd27) begin
          mmode = M_HALT; mhalt = 1'b1;
        end else begin
          append_exec(IR[31:27]);
        end
      end
      if (mmode == M_RUN && mq.size() == 0) begin
        if (stop) mmode = M_HALT;
        else load_fetch();
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  logic [3:0]  exp_step;
  logic [24:0] exp_vec;
  logic [4:0]  exp_alu;
  int cyc = 0;

  always @(negedge clk) begin
    cyc++;
    exp_step = 4'd0; exp_vec = '0; exp_alu = 5'd0;
    if (!clr) begin
      if (mmode == M_HALT) exp_step = 4'd15;
      else if (mmode == M_RUN && mq.size() > 0) begin
        exp_step = mq[0].step; exp_vec = mq[0].vec; exp_alu = mq[0].alu;
      end
    end
    n_chk++;
    if (step !== exp_step || dut_vec !== exp_vec || alu_op !== exp_alu) begin
      n_fail++;
      $display("FAIL cycle %0d: step=%0d strobes=%h alu_op=%b, model expects step=%0d strobes=%h alu_op=%b",
               cyc, step, dut_vec, alu_op, exp_step, exp_vec, exp_alu);
    end
  end

  // ---------------- literal pins and stimulus ----------------
  task automatic pin(input string nm, input logic [3:0] es, input logic [24:0] ev, input logic [4:0] ea);
    n_chk++;
    if (step !== es || dut_vec !== ev || alu_op !== ea) begin
      n_fail++;
      $display("FAIL %s: got step=%0d strobes=%h alu_op=%b, want step=%0d strobes=%h alu_op=%b",
               nm, step, dut_vec, alu_op, es, ev, ea);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int halted_cnt;
    clr = 1'b1; stop = 1'b0; IR = IR_ADD;

    // reset hold, RST cycle, fetch
    tick(); pin("clr_hold", 4'd0, '0, 5'd0);
    tick(); clr = 1'b0; #1;
    pin("rst_cycle", 4'd0, '0, 5'd0);
    tick(); pin("fetch_t0", 4'd1, PCOUT | MARIN | INCPC | ZIN | RUN, 5'd0);
    tick(); pin("fetch_t1", 4'd2, ZLO | PCIN | READ | MDRIN | RUN, 5'd0);
    tick(); pin("fetch_t2", 4'd3, MDROUT | IRIN | RUN, 5'd0);

    // add R5,R2,R3
    tick(); pin("add_t3", 4'd4, GRB | ROUT | YIN | RUN, 5'd0);
    tick(); pin("add_t4", 4'd5, GRC | ROUT | ZIN | RUN, 5'b00011);
    tick(); pin("add_t5", 4'd6, ZLO | GRA | RIN | RUN, 5'd0);
    tick(); pin("add_next_t0", 4'd1, PCOUT | MARIN | INCPC | ZIN | RUN, 5'd0);

    // div R2,R3
    IR = IR_DIV;
    ticks(3); pin("div_t3", 4'd4, GRA | ROUT | YIN | RUN, 5'd0);
    tick();   pin("div_t4", 4'd5, GRB | ROUT | ZIN | RUN, 5'b01111);
    tick();   pin("div_t5", 4'd6, ZLO | LOIN | RUN, 5'd0);
    tick();   pin("div_t6", 4'd7, ZHI | HIIN | RUN, 5'd0);
    tick();   pin("div_next_t0", 4'd1, PCOUT | MARIN | INCPC | ZIN | RUN, 5'd0);

    // ld R1,0x55(R0)
    IR = IR_LD;
    ticks(3); pin("ld_t3", 4'd4, GRB | BAOUT | YIN | RUN, 5'd0);
    tick();   pin("ld_t4", 4'd5, COUT | ZIN | RUN, ADD_OP);
    tick();   pin("ld_t5", 4'd6, ZLO | MARIN | RUN, 5'd0);
    tick();   pin("ld_t6", 4'd7, READ | MDRIN | RUN, 5'd0);
    tick();   pin("ld_t7", 4'd8, MDROUT | GRA | RIN | RUN, 5'd0);
    tick();   pin("ld_next_t0", 4'd1, PCOUT | MARIN | INCPC | ZIN | RUN, 5'd0);

    // stop raised during T4 of add: finish the instruction, halt, then resume
    IR = IR_ADD;
    ticks(4); stop = 1'b1;
    tick(); pin("stop_t5_completes", 4'd6, ZLO | GRA | RIN | RUN, 5'd0);
    tick(); pin("stop_halted", 4'd15, '0, 5'd0);
    stop = 1'b0;
    tick(); pin("stop_resume_t0", 4'd1, PCOUT | MARIN | INCPC | ZIN | RUN, 5'd0);

    // clr during T4 of add: outputs drop at once, no Rin pulse follows
    ticks(4); clr = 1'b1; #1;
    pin("clr_mid_instr", 4'd0, '0, 5'd0);
    tick(); clr = 1'b0; #1;
    pin("clr_mid_rst", 4'd0, '0, 5'd0);
    tick(); pin("clr_mid_t0", 4'd1, PCOUT | MARIN | INCPC | ZIN | RUN, 5'd0);

    // halt instruction: stays halted while stop toggles, only clr leaves
    IR = IR_HALT;
    ticks(3); pin("halt_enter", 4'd15, '0, 5'd0);
    for (int k = 0; k < 20; k++) begin
      stop = ~stop;
      tick();
    end
    stop = 1'b0;
    pin("halt_sticky", 4'd15, '0, 5'd0);
    clr = 1'b1; tick(); clr = 1'b0;
    tick(); pin("halt_clr_t0", 4'd1, PCOUT | MARIN | INCPC | ZIN | RUN, 5'd0);

    // nop: T2 straight back to T0
    IR = IR_NOP;
    ticks(3); pin("nop_t0", 4'd1, PCOUT | MARIN | INCPC | ZIN | RUN, 5'd0);

    // randomized traffic; IR only changes at T0 so it is stable across T3..next T2
    halted_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (mmode == M_RUN && mq.size() > 0 && mq[0].step == 4'd1) IR = $urandom;
      stop = ($urandom_range(0, 7) == 0);
      halted_cnt = (mmode == M_HALT) ? halted_cnt + 1 : 0;
      clr = (halted_cnt > 6) || ($urandom_range(0, 199) == 0);
      tick();
    end
    clr = 1'b1; stop = 1'b0;
    ticks(2);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
